abs_normalize_stage: RTL and testbench

Two-stage pipelined absolute-value and normalization stage for 19-bit two's-complement results from the iterative arithmetic datapath. Stage 1 captures the operand and forms its ones' complement when negative. Stage 2 applies the +1 increment chain, selects the magnitude, and left-normalizes it with a leading-zero count. It sits between the result register of the iterative unit and the rounding/packing logic, with valid/ready flow control on both sides.

---
 rtl/abs_normalize_stage_if.sv | 43 ++++
 rtl/abs_normalize_stage.sv | 95 +++++++++
 tb/tb_abs_normalize_stage.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/abs_normalize_stage_if.sv
// abs_normalize_stage_if: valid/ready bus for abs_normalize_stage.
// Ports: in_valid/in_ready/in_data upstream; out_valid/out_ready/out_* downstream.
interface abs_normalize_stage_if #(
  parameter int W  = 19,
  parameter int SW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [W-1:0]  out_mag;
  logic [W-1:0]  out_norm;
  logic [SW-1:0] out_shamt;
  logic          out_zero;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sign,
    input  out_mag,
    input  out_norm,
    input  out_shamt,
    input  out_zero
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sign,
    output out_mag,
    output out_norm,
    output out_shamt,
    output out_zero
  );
endinterface

// File: rtl/abs_normalize_stage.sv
// abs_normalize_stage: 2-stage |x| plus left-normalize with leading-zero count.
// Ports: clk, reset (sync, active-high), bus (slave: in_* upstream, out_* downstream).
module abs_normalize_stage #(
  parameter int W  = 19,
  parameter int SW = 5
) (
  input logic                  clk,
  input logic                  reset,
  abs_normalize_stage_if.slave bus
);

  logic          s1_v;
  logic          s2_v;
  logic          s1_en;
  logic          s2_en;

  logic          sign1;
  logic [W-1:0]  oc1;

  logic [W-1:0]  mag;
  logic [W-1:0]  norm;
  logic [SW-1:0] shamt;

  logic          sign2;
  logic          zero2;
  logic [W-1:0]  mag2;
  logic [W-1:0]  norm2;
  logic [SW-1:0] sh2;

  assign s2_en = !s2_v || bus.out_ready;
  assign s1_en = !s1_v || s2_en;

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = s2_v;
  assign bus.out_sign  = sign2;
  assign bus.out_mag   = mag2;
  assign bus.out_norm  = norm2;
  assign bus.out_shamt = sh2;
  assign bus.out_zero  = zero2;

  // Ripple +1 on the ones' complement; carry-in is the sign,
  // the final carry-out is dropped.
  always_comb begin : inc
    logic c;
    c   = sign1;
    mag = '0;
    for (int i = 0; i < W; i++) begin
      mag[i] = oc1[i] ^ c;
      c      = oc1[i] & c;
    end
  end

  // Highest set bit wins; all-zero leaves the count at W,
  // which also shifts everything out of norm.
  always_comb begin : lzc
    shamt = SW'(W);
    for (int i = 0; i < W; i++) begin
      if (mag[i]) begin
        shamt = SW'(W - 1 - i);
      end
    end
    norm = mag << shamt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v  <= 1'b0;
      sign1 <= 1'b0;
      oc1   <= '0;
    end else if (s1_en) begin
      s1_v  <= bus.in_valid;
      sign1 <= bus.in_data[W-1];
      oc1   <= bus.in_data ^ {W{bus.in_data[W-1]}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v  <= 1'b0;
      sign2 <= 1'b0;
      mag2  <= '0;
      norm2 <= '0;
      sh2   <= '0;
      zero2 <= 1'b0;
    end else if (s2_en) begin
      s2_v  <= s1_v;
      sign2 <= sign1;
      mag2  <= mag;
      norm2 <= norm;
      sh2   <= shamt;
      zero2 <= (mag == '0);
    end
  end

endmodule

// File: tb/tb_abs_normalize_stage.sv
// tb_abs_normalize_stage: directed + random stream against an abs/lzc model.
// Drives bus master side; scoreboard checks every valid output cycle.
module tb_abs_normalize_stage;

  typedef struct {
    logic        sign;
    logic [18:0] mag;
    logic [18:0] norm;
    logic [4:0]  sh;
    logic        zero;
    int          cyc;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  res_t exp_q[$];
  res_t got_q[$];
  res_t snap;
  bit   stall_prev = 1'b0;

  abs_normalize_stage_if #(.W(19), .SW(5)) bus();

  abs_normalize_stage #(.W(19), .SW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [18:0] d);
    res_t r;
    int v;
    int m;
    int s;
    v = d[18] ? int'(d) - (1 << 19) : int'(d);
    m = (v < 0) ? -v : v;
    r.sign = d[18];
    r.mag  = 19'(m);
    r.zero = (m == 0);
    r.cyc  = 0;
    if (m == 0) begin
      r.sh   = 5'd19;
      r.norm = '0;
    end else begin
      s = 0;
      while ((m << s) < (1 << 18)) s++;
      r.sh   = 5'(s);
      r.norm = 19'(m << s);
    end
    return r;
  endfunction

  function automatic res_t cur();
    res_t r;
    r.sign = bus.out_sign;
    r.mag  = bus.out_mag;
    r.norm = bus.out_norm;
    r.sh   = bus.out_shamt;
    r.zero = bus.out_zero;
    r.cyc  = cyc;
    return r;
  endfunction

  function automatic bit same(input res_t a, input res_t b);
    return a.sign === b.sign && a.mag === b.mag &&
           a.norm === b.norm && a.sh === b.sh &&
           a.zero === b.zero;
  endfunction

  task automatic chk_res(input string nm, input res_t a, input res_t e);
    checks++;
    if (!same(a, e)) begin
      failures++;
      $display("FAIL %s got s=%b m=%h n=%h sh=%0d z=%b exp s=%b m=%h n=%h sh=%0d z=%b",
               nm, a.sign, a.mag, a.norm, a.sh, a.zero,
               e.sign, e.mag, e.norm, e.sh, e.zero);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  function automatic res_t lit(input logic s, input logic [18:0] m,
                               input logic [4:0] sh, input logic [18:0] n,
                               input logic z);
    res_t r;
    r.sign = s; r.mag = m; r.sh = sh; r.norm = n; r.zero = z; r.cyc = 0;
    return r;
  endfunction

  // Scoreboard: every non-reset cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk_res("hold", cur(), snap);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious out_valid got=1 exp=0");
        end else begin
          chk_res("stream", cur(), exp_q[0]);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            got_q.push_back(cur());
          end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_data));
      stall_prev = bus.out_valid && !bus.out_ready;
      snap = cur();
    end
  end

  task automatic push(input logic [18:0] d, input bit rnd);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    while (!bus.in_ready) begin
      guard++;
      if (guard > 60) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout got=0 exp=1");
        break;
      end
      @(posedge clk); #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [18:0] d;
    int guard;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // model pins
    chk_res("model_m1", model(19'h7FFFF), lit(1, 19'h00001, 18, 19'h40000, 0));
    chk_res("model_min", model(19'h40000), lit(1, 19'h40000, 0, 19'h40000, 0));
    chk_res("model_zero", model(19'h00000), lit(0, 19'h0, 19, 19'h0, 1));

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk_res("rst_outs", cur(), lit(0, 0, 0, 0, 0));

    // -1 with latency check
    bus.out_ready = 1'b1;
    got_q.delete();
    push(19'h7FFFF, 0);
    idle();
    @(negedge clk);
    chk("lat_n", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_n1", 32'(bus.out_valid), 1);
    repeat (3) @(posedge clk);
    chk("neg1_cnt", got_q.size(), 1);
    if (got_q.size() >= 1)
      chk_res("neg1", got_q[0], lit(1, 19'h00001, 18, 19'h40000, 0));

    // most negative
    got_q.delete();
    push(19'h40000, 0);
    idle();
    repeat (4) @(posedge clk);
    chk("min_cnt", got_q.size(), 1);
    if (got_q.size() >= 1)
      chk_res("min", got_q[0], lit(1, 19'h40000, 0, 19'h40000, 0));

    // positive then zero back to back
    got_q.delete();
    push(19'h00005, 0);
    push(19'h00000, 0);
    idle();
    repeat (4) @(posedge clk);
    chk("b2b_cnt", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk_res("pos5", got_q[0], lit(0, 19'h5, 16, 19'h50000, 0));
      chk_res("zero", got_q[1], lit(0, 19'h0, 19, 19'h0, 1));
      chk("b2b_gap", got_q[1].cyc, got_q[0].cyc + 1);
    end

    // backpressure
    got_q.delete();
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 19'h00003;
    @(negedge clk);
    chk("bp_rdy0", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_data = 19'h7FFFE;
    @(negedge clk);
    chk("bp_rdy1", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_data = 19'h00100;
    @(negedge clk);
    chk("bp_full", 32'(bus.in_ready), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_full_hold", 32'(bus.in_ready), 0);
    chk("bp_none_out", got_q.size(), 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_same_cyc", 32'(bus.in_ready), 1);
    idle();
    repeat (5) @(posedge clk);
    chk("bp_cnt", got_q.size(), 3);
    if (got_q.size() >= 3) begin
      chk_res("bp0", got_q[0], lit(0, 19'h3, 17, 19'h60000, 0));
      chk_res("bp1", got_q[1], lit(1, 19'h2, 17, 19'h40000, 0));
      chk_res("bp2", got_q[2], lit(0, 19'h100, 10, 19'h40000, 0));
    end

    // reset mid-stream
    got_q.delete();
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    push(19'h00011, 0);
    push(19'h00022, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 32'(bus.out_valid), 0);
    chk("mrst_ready", 32'(bus.in_ready), 1);
    chk_res("mrst_outs", cur(), lit(0, 0, 0, 0, 0));
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    chk("mrst_dropped", got_q.size(), 0);

    // random stream
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 15))
        0: d = 19'h00000;
        1: d = 19'h40000;
        2: d = 19'h7FFFF;
        3: d = 19'(1 << $urandom_range(0, 18));
        default: d = 19'($urandom);
      endcase
      push(d, 1);
    end
    idle();
    bus.out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
